bar_uart_rx_fifo: RTL and testbench



---
 rtl/bar_uart_rx_fifo.sv | 196 +++++++++++++++++++
 tb/tb_bar_uart_rx_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bar_uart_rx_fifo.sv
// 8N1 UART receiver for the SoC TX line, buffered in a FIFO and exposed as a 4-register BAR window.
// RXDATA pops on read; STATUS/CTRL carry FIFO state, sticky error flags and flush.
module bar_uart_rx_fifo #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        soc_uart_tx,
    input  logic [31:0] bar_addr,
    input  logic [31:0] bar_wdata,
    input  logic        bar_wen,
    input  logic        bar_ren,
    output logic [31:0] bar_rdata,
    output logic        rx_irq
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [8:0] DepthCnt = 9'(FIFO_DEPTH);
    localparam logic [15:0] ResetDiv = 16'(CLK_DIV);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

    // Input synchronizer plus edge-detect history.
    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= soc_uart_tx;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    rx_state_e   state_q;
    logic [15:0] timer_q;
    logic [15:0] frame_div_q;
    logic [15:0] div_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        expire;
    logic        rx_push;
    logic        rx_ferr;

    assign expire  = (state_q != StIdle) && (timer_q == 16'd1);
    assign rx_push = (state_q == StStop) && expire && sync_q;
    assign rx_ferr = (state_q == StStop) && expire && !sync_q;

    // The divisor is latched at the start edge so DIV writes never disturb a frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= 16'd0;
            frame_div_q <= ResetDiv;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (prev_q && !sync_q) begin
                        frame_div_q <= div_q;
                        timer_q     <= div_q >> 1;
                        state_q     <= StStart;
                    end
                end
                StStart: begin
                    if (expire) begin
                        if (sync_q) begin
                            state_q <= StIdle;
                        end else begin
                            timer_q   <= frame_div_q;
                            bit_idx_q <= 3'd0;
                            state_q   <= StData;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                StData: begin
                    if (expire) begin
                        shift_q[bit_idx_q] <= sync_q;
                        timer_q            <= frame_div_q;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                StStop: begin
                    if (expire) begin
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [8:0]      count_q, count_d;
    logic            ovf_q, ovf_d, ferr_q, ferr_d;
    logic [15:0]     div_d;
    logic [31:0]     rdata_d;
    logic            sel_data, sel_status, sel_ctrl, sel_div;
    logic            full, pop, flush, push_ok, ctrl_wr;
    logic            unused_wdata;

    assign sel_data     = bar_addr == BASE_ADDR;
    assign sel_status   = bar_addr == BASE_ADDR + 32'h4;
    assign sel_ctrl     = bar_addr == BASE_ADDR + 32'h8;
    assign sel_div      = bar_addr == BASE_ADDR + 32'hC;
    assign unused_wdata = ^bar_wdata[31:16];

    always_comb begin
        full    = count_q == DepthCnt;
        ctrl_wr = bar_wen && sel_ctrl;
        pop     = bar_ren && sel_data && (count_q != 9'd0);
        flush   = ctrl_wr && bar_wdata[2];
        push_ok = rx_push && !flush && (!full || pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 9'd0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
            if (pop)     rd_ptr_d = rd_ptr_q + PtrOne;
            if (push_ok && !pop)      count_d = count_q + 9'd1;
            else if (pop && !push_ok) count_d = count_q - 9'd1;
        end

        // Set beats clear; a flushed push is dropped silently.
        ovf_d  = (ovf_q && !(ctrl_wr && bar_wdata[0])) || (rx_push && !flush && full && !pop);
        ferr_d = (ferr_q && !(ctrl_wr && bar_wdata[1])) || rx_ferr;

        div_d = div_q;
        if (bar_wen && sel_div) begin
            div_d = (bar_wdata[15:0] < 16'd4) ? 16'd4 : bar_wdata[15:0];
        end

        rdata_d = bar_rdata;
        if (bar_ren) begin
            if (sel_data) begin
                rdata_d = (count_q != 9'd0) ? {23'h0, 1'b1, mem[rd_ptr_q]} : 32'h0;
            end else if (sel_status) begin
                rdata_d = {15'h0, count_q, 4'h0, ferr_q, ovf_q, full, count_q != 9'd0};
            end else if (sel_div) begin
                rdata_d = {16'h0, div_q};
            end else begin
                rdata_d = 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 9'd0;
            ovf_q     <= 1'b0;
            ferr_q    <= 1'b0;
            div_q     <= ResetDiv;
            bar_rdata <= 32'h0;
            rx_irq    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            ferr_q    <= ferr_d;
            div_q     <= div_d;
            bar_rdata <= rdata_d;
            rx_irq    <= count_d != 9'd0;
        end
    end

endmodule

// File: tb/tb_bar_uart_rx_fifo.sv
// Bench for bar_uart_rx_fifo: directed corner cases plus randomized traffic
// checked against a queue-based model of the receive FIFO and its flags.
module tb_bar_uart_rx_fifo;

    localparam logic [31:0] Base   = 32'h2000;
    localparam logic [31:0] AData  = Base;
    localparam logic [31:0] AStat  = Base + 32'h4;
    localparam logic [31:0] ACtrl  = Base + 32'h8;
    localparam logic [31:0] ADiv   = Base + 32'hC;
    localparam int          Depth  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        line;
    logic [31:0] addr, wdata, rdata;
    logic        wen, ren, irq;

    bar_uart_rx_fifo #(
        .CLK_DIV   (868),
        .FIFO_DEPTH(Depth),
        .BASE_ADDR (Base)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .soc_uart_tx(line),
        .bar_addr   (addr),
        .bar_wdata  (wdata),
        .bar_wen    (wen),
        .bar_ren    (ren),
        .bar_rdata  (rdata),
        .rx_irq     (irq)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: byte queue plus sticky flags.
    logic [7:0]  q[$];
    logic        m_ovf  = 1'b0;
    logic        m_ferr = 1'b0;
    int          cur_div = 868;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s = '0;
        s[16:8] = 9'(q.size());
        s[3]    = m_ferr;
        s[2]    = m_ovf;
        s[1]    = (q.size() == Depth);
        s[0]    = (q.size() != 0);
        return s;
    endfunction

    function automatic logic [31:0] model_pop();
        if (q.size() == 0) return 32'h0;
        return {23'h0, 1'b1, q.pop_front()};
    endfunction

    task automatic model_rx(input logic [7:0] b, input logic good);
        if (!good) m_ferr = 1'b1;
        else if (q.size() == Depth) m_ovf = 1'b1;
        else q.push_back(b);
    endtask

    task automatic model_ctrl(input logic [2:0] c);
        if (c[0]) m_ovf = 1'b0;
        if (c[1]) m_ferr = 1'b0;
        if (c[2]) q.delete();
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bar_read(input logic [31:0] a, output logic [31:0] d);
        ren = 1'b1;
        addr = a;
        idle(1);
        ren = 1'b0;
        d = rdata;
    endtask

    task automatic bar_write(input logic [31:0] a, input logic [31:0] d);
        wen = 1'b1;
        addr = a;
        wdata = d;
        idle(1);
        wen = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic good_stop);
        line = 1'b0;
        idle(cur_div);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            idle(cur_div);
        end
        line = good_stop;
        idle(cur_div);
        line = 1'b1;
        idle(2);
    endtask

    task automatic set_div(input int d);
        bar_write(ADiv, 32'(d));
        cur_div = d;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        e = exp_status();
        bar_read(AStat, d);
        check_eq(tag, d, e);
    endtask

    task automatic check_pop(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        e = model_pop();
        bar_read(AData, d);
        check_eq(tag, d, e);
    endtask

    // Edge index, counted from the start-bit edge, at which the stop-bit sample lands:
    // 2 synchronizer flops + edge detect, then half a bit, then nine full bits.
    function automatic int push_edge();
        return 3 + cur_div / 2 + 9 * cur_div;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          rise;
        int          n;

        rst = 1'b1;
        line = 1'b1;
        addr = '0;
        wdata = '0;
        wen = 1'b0;
        ren = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check_eq("reset_rdata", rdata, 32'h0);
        check_eq("reset_irq", {31'h0, irq}, 32'h0);
        check_status("reset_status");
        bar_read(ADiv, d);
        check_eq("reset_div", d, 32'd868);
        check_pop("reset_rxdata_empty");
        bar_read(ACtrl, d);
        check_eq("ctrl_reads_zero", d, 32'h0);
        bar_read(Base + 32'h40, d);
        check_eq("unmapped_reads_zero", d, 32'h0);

        // Single byte and interrupt latency
        set_div(8);
        rise = -1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int c = 1; c <= 10 * 8 + 2; c++) begin
                    @(posedge clk);
                    #1;
                    if (irq && rise < 0) rise = c;
                end
            end
        join
        model_rx(8'hA5, 1'b1);
        check_eq("irq_rise_window", {31'h0, (rise >= 9 * 8 + 4) && (rise <= 9 * 8 + 4 + 3)}, 32'h1);
        check_status("status_one_byte");
        bar_read(AData, d);
        check_eq("rxdata_a5", d, 32'h1A5);
        void'(model_pop());
        check_status("status_after_pop");
        check_eq("irq_after_pop", {31'h0, irq}, 32'h0);

        // Overflow with 17 bytes
        for (int i = 0; i <= 16; i++) begin
            send_frame(8'(i), 1'b1);
            model_rx(8'(i), 1'b1);
        end
        check_status("status_overflow");
        check_eq("irq_full", {31'h0, irq}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            bar_read(AData, d);
            check_eq($sformatf("ovf_read_%0d", i), d, 32'h100 + 32'(i));
            void'(model_pop());
        end
        bar_write(ACtrl, 32'h1);
        model_ctrl(3'b001);
        check_status("status_ovf_cleared");

        // Framing error, then recovery
        send_frame(8'h55, 1'b0);
        model_rx(8'h55, 1'b0);
        check_status("status_frame_err");
        send_frame(8'h3C, 1'b1);
        model_rx(8'h3C, 1'b1);
        check_pop("rxdata_after_ferr");
        bar_write(ACtrl, 32'h2);
        model_ctrl(3'b010);
        check_status("status_ferr_cleared");

        // Short glitch is a false start
        line = 1'b0;
        idle(3);
        line = 1'b1;
        idle(40);
        check_status("status_after_glitch");
        bar_write(ADiv, 32'h2);
        bar_read(ADiv, d);
        check_eq("div_clamped", d, 32'h4);
        set_div(8);

        // Pop coinciding with a push into a full FIFO
        for (int i = 0; i < Depth; i++) begin
            send_frame(8'h80 + 8'(i), 1'b1);
            model_rx(8'h80 + 8'(i), 1'b1);
        end
        n = push_edge();
        fork
            send_frame(8'hEE, 1'b1);
            begin
                idle(n - 1);
                ren = 1'b1;
                addr = AData;
                idle(1);
                ren = 1'b0;
                d = rdata;
            end
        join
        check_eq("pop_at_push_data", d, model_pop());
        model_rx(8'hEE, 1'b1);
        check_status("status_pop_at_push");

        // Flush coinciding with a push into a full FIFO
        fork
            send_frame(8'h77, 1'b1);
            begin
                idle(n - 1);
                bar_write(ACtrl, 32'h4);
            end
        join
        model_ctrl(3'b100);
        check_status("status_flush_at_push");
        check_eq("irq_after_flush", {31'h0, irq}, 32'h0);

        // Randomized traffic
        for (int r = 0; r < 40; r++) begin
            int w;
            w = $urandom_range(0, 20);
            bar_write(ADiv, 32'(w));
            bar_read(ADiv, d);
            check_eq("rand_div_readback", d, (w < 4) ? 32'd4 : 32'(w));
            if (w < 8) w = $urandom_range(8, 20);
            set_div(w);
            for (int k = $urandom_range(1, 8); k > 0; k--) begin
                int act;
                act = $urandom_range(0, 19);
                if (act < 10) begin
                    logic [7:0] b;
                    logic       good;
                    b = 8'($urandom);
                    good = ($urandom_range(0, 7) != 0);
                    send_frame(b, good);
                    model_rx(b, good);
                end else if (act < 15) begin
                    check_pop("rand_rxdata");
                end else if (act < 18) begin
                    check_status("rand_status");
                end else begin
                    logic [2:0] c;
                    c = 3'($urandom);
                    bar_write(ACtrl, {29'h0, c});
                    model_ctrl(c);
                end
            end
            check_eq("rand_irq", {31'h0, irq}, {31'h0, q.size() != 0});
        end
        check_status("rand_final_status");

        // Reset in the middle of a frame
        set_div(8);
        line = 1'b0;
        idle(30);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        line = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        m_ferr = 1'b0;
        idle(100);
        check_status("status_after_midframe_reset");
        bar_read(ADiv, d);
        check_eq("div_after_reset", d, 32'd868);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
